burst_window_ctrl: RTL and testbench
====================================

# burst_window_ctrl

Consumes the single-bit output of the cross-clock-domain delay shift register and turns each rising edge into a fixed-length enable window for the downstream online-arithmetic datapath. It produces a registered burst enable with a per-cycle index, a done/acknowledge handshake, a saturating burst counter and a sticky missed-trigger flag. It sits directly downstream of the synchronizer, in the destination clock domain.

## Interface
- BURST_LEN, 16: cycles `burst_en` is held per window; legal range ≥ 2.
- GAP_CYCLES, 2: idle cycles enforced after acknowledge before re-arming; 0 is legal.
- CNT_WIDTH, 8: width of `burst_count`.
- clk  in  1  destination-domain clock; all state on rising edge.
- reset  in  1  asynchronous, active-low: asserted at 0, clears all state immediately; release is synchronous to `clk` upstream.
- sync_in  in  1  synchronized trigger level from the delay shift register.
- ack_in  in  1  consumer acknowledges `done`.
- clear_missed  in  1  synchronous clear of `missed`.
- burst_en  out  1  high during the window.
- burst_idx  out  $clog2(BURST_LEN)  0..BURST_LEN-1 inside the window, 0 otherwise.
- done  out  1  window finished, awaiting `ack_in`.
- busy  out  1  high in any state except IDLE.
- burst_count  out  CNT_WIDTH  windows started; saturates at all-ones.
- missed  out  1  sticky: a trigger edge arrived while not in IDLE.

## Operation
- Edge detect: `sync_d` register; `edge = sync_in & ~sync_d`. `sync_d` resets to 1, so a level already high at reset release does not trigger.
- FSM states: IDLE, BURST, DONE, GAP.
- IDLE: on `edge` -> BURST; `burst_count` += 1 (saturating).
- BURST: `burst_en`=1 and `burst_idx` counts 0..BURST_LEN-1. After the cycle with idx = BURST_LEN-1 -> DONE.
- DONE: `done`=1, held until `ack_in`=1. With GAP_CYCLES>0 -> GAP, else -> IDLE.
- GAP: counts GAP_CYCLES cycles, then -> IDLE.
- `edge` in BURST, DONE or GAP sets `missed` (see Configuration for BURST). No window starts and no count occurs.
- `clear_missed` and a new missed edge in the same cycle: set wins.
- `ack_in` outside DONE is ignored.
- `ack_in` and `edge` in the same DONE cycle: the ack is honoured and the edge sets `missed`.

## Timing
- Reset values: `burst_en`=0, `burst_idx`=0, `done`=0, `busy`=0, `burst_count`=0, `missed`=0, state IDLE, `sync_d`=1.
- All outputs are registered.
- If `sync_in` rises in cycle t (`sync_d`=0), `burst_en` and `busy` go high in cycle t+1 with idx 0. `burst_en` stays high through cycle t+BURST_LEN.
- `done` goes high in cycle t+BURST_LEN+1.
- An ack sampled in cycle a drops `done` in cycle a+1. `busy` drops in cycle a+1+GAP_CYCLES.
- The earliest re-trigger edge is accepted in the first IDLE cycle.
- `burst_count` updates in the same cycle `burst_en` first rises.
- Reset asserted mid-window forces all outputs to their reset values without waiting for a clock edge. There is no partial-window completion.

## Configuration
- BURST_WINDOW_RETRIGGER_EN
  - Defined: an `edge` in BURST restarts `burst_idx` at 0 in the next cycle, extends the window, increments `burst_count` and does not set `missed`.
  - Undefined: an edge in BURST only sets `missed`.
  - Behaviour in DONE and GAP is identical either way.

## Test plan
- Single trigger, BURST_LEN=16, GAP=2: `sync_in` 0→1 at cycle 10 -> `burst_en` high cycles 11–26, idx 0..15, `done` high at 27. Ack at 30 -> `done` low at 31, `busy` low at 33, `burst_count`=1.
- Trigger during BURST (macro undefined): second rise at cycle 15 -> window still ends at 26, `missed`=1, `burst_count`=1. Then `clear_missed` pulse -> `missed`=0 next cycle.
- Same stimulus with BURST_WINDOW_RETRIGGER_EN: idx returns to 0 at cycle 16, `burst_en` high through 31, `burst_count`=2, `missed`=0.
- Level high at reset release: `sync_in`=1 while reset deasserts -> no window. A later 0→1 transition -> window starts one cycle after the edge.
- Reset mid-window: reset low at idx 7 -> all outputs 0 immediately. After release, idle until the next edge.
- Counter saturation, CNT_WIDTH=2: 5 separate acked windows -> `burst_count` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/burst_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : burst_window_ctrl
// Brief    : Turns each rising edge of a synchronized trigger into a fixed
//            BURST_LEN-cycle enable window with index, done/ack handshake,
//            saturating window counter and sticky missed-trigger flag.
//            Optional macro BURST_WINDOW_RETRIGGER_EN: an edge inside the
//            window restarts it instead of flagging a miss.
// Revision : 1.0 - initial release
// ============================================================================
module burst_window_ctrl #(
    parameter int BURST_LEN  = 16,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sync_in,
    input  logic                         ack_in,
    input  logic                         clear_missed,
    output logic                         burst_en,
    output logic [$clog2(BURST_LEN)-1:0] burst_idx,
    output logic                         done,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         burst_count,
    output logic                         missed
);

    localparam int c_IDX_W = $clog2(BURST_LEN);
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_IDX_W-1:0]   c_IDX_LAST = c_IDX_W'(BURST_LEN - 1);
    localparam logic [c_GAP_W-1:0]   c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_BURST = 2'd1,
        c_DONE  = 2'd2,
        c_GAP   = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_sync_d;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic                 r_burst_en;
    logic                 r_done;
    logic                 r_busy;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_missed;

    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [c_GAP_W-1:0]   w_gap_nxt;
    logic                 w_edge;
    logic                 w_start;
    logic                 w_miss;

    // r_sync_d resets high so a level already present at reset release is not an edge
    assign w_edge = sync_in & ~r_sync_d;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = '0;
        w_gap_nxt   = '0;
        w_start     = 1'b0;
        w_miss      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_edge) begin
                    w_state_nxt = c_BURST;
                    w_start     = 1'b1;
                end
            end
            c_BURST: begin
`ifdef BURST_WINDOW_RETRIGGER_EN
                if (w_edge) begin
                    w_start   = 1'b1;
                    w_idx_nxt = '0;
                end else if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = c_DONE;
                end else begin
                    w_idx_nxt = r_idx + c_IDX_W'(1);
                end
`else
                w_miss = w_edge;
                if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = c_DONE;
                end else begin
                    w_idx_nxt = r_idx + c_IDX_W'(1);
                end
`endif
            end
            c_DONE: begin
                w_miss = w_edge;
                if (ack_in) begin
                    w_state_nxt = (GAP_CYCLES > 0) ? c_GAP : c_IDLE;
                end
            end
            c_GAP: begin
                w_miss = w_edge;
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + c_GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with r_state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_sync_d   <= 1'b1;
            r_idx      <= '0;
            r_gap_cnt  <= '0;
            r_burst_en <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_count    <= '0;
            r_missed   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_d   <= sync_in;
            r_idx      <= w_idx_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_burst_en <= (w_state_nxt == c_BURST);
            r_done     <= (w_state_nxt == c_DONE);
            r_busy     <= (w_state_nxt != c_IDLE);
            if (w_start && (r_count != c_CNT_MAX)) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
            // A new miss takes priority over a simultaneous clear
            if (w_miss) begin
                r_missed <= 1'b1;
            end else if (clear_missed) begin
                r_missed <= 1'b0;
            end
        end
    end

    assign burst_en    = r_burst_en;
    assign burst_idx   = r_idx;
    assign done        = r_done;
    assign busy        = r_busy;
    assign burst_count = r_count;
    assign missed      = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_burst_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_window_ctrl
// Brief    : Directed self-checking bench for burst_window_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_window_ctrl;

`ifdef BURST_WINDOW_RETRIGGER_EN
    localparam int c_RETRIG = 1;
`else
    localparam int c_RETRIG = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sync_in, ack_in, clear_missed;
    logic       burst_en, done, busy, missed;
    logic [3:0] burst_idx;
    logic [7:0] burst_count;

    logic       sync2, ack2, clr2;
    logic       burst_en2, done2, busy2, missed2;
    logic [1:0] idx2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    burst_window_ctrl #(.BURST_LEN(16), .GAP_CYCLES(2), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .sync_in(sync_in), .ack_in(ack_in),
        .clear_missed(clear_missed), .burst_en(burst_en), .burst_idx(burst_idx),
        .done(done), .busy(busy), .burst_count(burst_count), .missed(missed)
    );

    burst_window_ctrl #(.BURST_LEN(4), .GAP_CYCLES(0), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset(reset), .sync_in(sync2), .ack_in(ack2),
        .clear_missed(clr2), .burst_en(burst_en2), .burst_idx(idx2),
        .done(done2), .busy(busy2), .burst_count(cnt2), .missed(missed2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; sync_in = 1'b0; ack_in = 1'b0; clear_missed = 1'b0;
        sync2 = 1'b0; ack2 = 1'b0; clr2 = 1'b0;
        #1;
        checks++;
        if ({burst_en, burst_idx, done, busy, burst_count, missed} !== 16'h0) begin
            errors++; $display("FAIL reset_async: got %h want 0", {burst_en, burst_idx, done, busy, burst_count, missed});
        end
        step(); step();
        reset = 1'b1;
        step();
        checks++;
        if ({burst_en, burst_idx, done, busy, burst_count, missed} !== 16'h0) begin
            errors++; $display("FAIL reset_idle: got %h want 0", {burst_en, burst_idx, done, busy, burst_count, missed});
        end
    endtask

    task automatic test_single();
        sync_in = 1'b1;
        step();
        exp_cnt = 1;
        checks++;
        if ({busy, burst_count} !== {1'b1, 8'(exp_cnt)}) begin
            errors++; $display("FAIL single_start: busy/count got %b/%0d want 1/%0d", busy, burst_count, exp_cnt);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({burst_en, burst_idx} !== {1'b1, 4'(k)}) begin
                errors++; $display("FAIL single_window k=%0d: en/idx got %b/%0d want 1/%0d", k, burst_en, burst_idx, k);
            end
            step();
        end
        checks++;
        if ({burst_en, done, busy} !== 3'b011) begin
            errors++; $display("FAIL single_done: en/done/busy got %b want 011", {burst_en, done, busy});
        end
        step(); step();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL single_done_hold: got %b want 1", done);
        end
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        checks++;
        if ({done, busy} !== 2'b01) begin
            errors++; $display("FAIL single_ack: done/busy got %b want 01", {done, busy});
        end
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL single_gap: busy got %b want 1", busy);
        end
        step();
        checks++;
        if ({busy, burst_count} !== {1'b0, 8'(exp_cnt)}) begin
            errors++; $display("FAIL single_idle: busy/count got %b/%0d want 0/%0d", busy, burst_count, exp_cnt);
        end
    endtask

    task automatic test_missed();
        sync_in = 1'b0;
        step();
        sync_in = 1'b1;
        step();
        exp_cnt++;
        checks++;
        if ({burst_en, burst_idx} !== 5'b1_0000) begin
            errors++; $display("FAIL missed_start: en/idx got %b/%0d want 1/0", burst_en, burst_idx);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (burst_idx !== 4'(k)) begin
                errors++; $display("FAIL missed_idx k=%0d: got %0d want %0d", k, burst_idx, k);
            end
            if (k == 2) sync_in = 1'b0;
            if (k == 3) ack_in = 1'b1;
            if (k == 4) begin ack_in = 1'b0; sync_in = 1'b1; end
        end
        step();
        exp_cnt = exp_cnt + c_RETRIG;
        checks++;
        if ({burst_idx, missed, burst_count} !== {4'(c_RETRIG ? 0 : 5), 1'(1 - c_RETRIG), 8'(exp_cnt)}) begin
            errors++; $display("FAIL missed_edge: idx/missed/count got %0d/%b/%0d want %0d/%0d/%0d",
                burst_idx, missed, burst_count, c_RETRIG ? 0 : 5, 1 - c_RETRIG, exp_cnt);
        end
        repeat (c_RETRIG ? 15 : 10) step();
        checks++;
        if ({burst_en, burst_idx} !== 5'b1_1111) begin
            errors++; $display("FAIL missed_last: en/idx got %b/%0d want 1/15", burst_en, burst_idx);
        end
        step();
        checks++;
        if ({burst_en, done} !== 2'b01) begin
            errors++; $display("FAIL missed_done: en/done got %b want 01", {burst_en, done});
        end
        clear_missed = 1'b1;
        step();
        clear_missed = 1'b0;
        checks++;
        if (missed !== 1'b0) begin
            errors++; $display("FAIL missed_clear: got %b want 0", missed);
        end
        sync_in = 1'b0;
        step();
        sync_in = 1'b1; clear_missed = 1'b1;
        step();
        clear_missed = 1'b0;
        checks++;
        if ({missed, done} !== 2'b11) begin
            errors++; $display("FAIL missed_set_wins: missed/done got %b want 11", {missed, done});
        end
        clear_missed = 1'b1;
        step();
        clear_missed = 1'b0;
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        checks++;
        if ({done, missed} !== 2'b00) begin
            errors++; $display("FAIL missed_ack: done/missed got %b want 00", {done, missed});
        end
        step(); step();
        checks++;
        if ({busy, burst_count} !== {1'b0, 8'(exp_cnt)}) begin
            errors++; $display("FAIL missed_idle: busy/count got %b/%0d want 0/%0d", busy, burst_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        sync_in = 1'b0;
        step();
        sync_in = 1'b1;
        step();
        exp_cnt++;
        sync_in = 1'b0;
        checks++;
        if ({burst_en, burst_count} !== {1'b1, 8'(exp_cnt)}) begin
            errors++; $display("FAIL b2b_start: en/count got %b/%0d want 1/%0d", burst_en, burst_count, exp_cnt);
        end
        repeat (16) step();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL b2b_done: got %b want 1", done);
        end
        ack_in = 1'b1; sync_in = 1'b1;
        step();
        ack_in = 1'b0; sync_in = 1'b0;
        checks++;
        if ({done, busy, missed, burst_count} !== {3'b011, 8'(exp_cnt)}) begin
            errors++; $display("FAIL b2b_ack_edge: done/busy/missed got %b count %0d want 011/%0d",
                {done, busy, missed}, burst_count, exp_cnt);
        end
        step(); step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: busy got %b want 0", busy);
        end
        sync_in = 1'b1;
        step();
        exp_cnt++;
        checks++;
        if ({burst_en, burst_idx, burst_count} !== {5'b1_0000, 8'(exp_cnt)}) begin
            errors++; $display("FAIL b2b_retrigger: en/idx/count got %b/%0d/%0d want 1/0/%0d",
                burst_en, burst_idx, burst_count, exp_cnt);
        end
        clear_missed = 1'b1;
        step();
        clear_missed = 1'b0;
        for (int i = 0; i < 40 && !done; i++) step();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL b2b_wait_done: timeout, done got %b want 1", done);
        end
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        step(); step();
        sync_in = 1'b0;
        checks++;
        if ({busy, missed} !== 2'b00) begin
            errors++; $display("FAIL b2b_end: busy/missed got %b want 00", {busy, missed});
        end
    endtask

    task automatic test_reset_level();
        reset = 1'b0; sync_in = 1'b1;
        #1;
        checks++;
        if ({burst_en, burst_idx, done, busy, burst_count, missed} !== 16'h0) begin
            errors++; $display("FAIL lvl_reset: got %h want 0", {burst_en, burst_idx, done, busy, burst_count, missed});
        end
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({burst_en, busy} !== 2'b00) begin
                errors++; $display("FAIL lvl_no_window i=%0d: en/busy got %b want 00", i, {burst_en, busy});
            end
        end
        sync_in = 1'b0;
        step();
        sync_in = 1'b1;
        step();
        checks++;
        if ({burst_en, burst_idx, burst_count} !== {5'b1_0000, 8'd1}) begin
            errors++; $display("FAIL lvl_edge: en/idx/count got %b/%0d/%0d want 1/0/1", burst_en, burst_idx, burst_count);
        end
    endtask

    task automatic test_reset_mid();
        repeat (7) step();
        checks++;
        if (burst_idx !== 4'd7) begin
            errors++; $display("FAIL mid_idx: got %0d want 7", burst_idx);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({burst_en, burst_idx, done, busy, burst_count, missed} !== 16'h0) begin
            errors++; $display("FAIL mid_async: got %h want 0", {burst_en, burst_idx, done, busy, burst_count, missed});
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({burst_en, busy, done} !== 3'b000) begin
                errors++; $display("FAIL mid_idle i=%0d: en/busy/done got %b want 000", i, {burst_en, busy, done});
            end
        end
        sync_in = 1'b0;
    endtask

    task automatic test_saturation();
        for (int n = 1; n <= 5; n++) begin
            sync2 = 1'b1;
            step();
            checks++;
            if ({burst_en2, cnt2} !== {1'b1, 2'((n > 3) ? 3 : n)}) begin
                errors++; $display("FAIL sat_count n=%0d: en/count got %b/%0d want 1/%0d", n, burst_en2, cnt2, (n > 3) ? 3 : n);
            end
            for (int i = 0; i < 10 && !done2; i++) step();
            checks++;
            if (done2 !== 1'b1) begin
                errors++; $display("FAIL sat_wait_done n=%0d: timeout, done got %b want 1", n, done2);
            end
            ack2 = 1'b1;
            step();
            ack2 = 1'b0; sync2 = 1'b0;
            checks++;
            if ({done2, busy2} !== 2'b00) begin
                errors++; $display("FAIL sat_nogap n=%0d: done/busy got %b want 00", n, {done2, busy2});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_missed();
        test_back_to_back();
        test_reset_level();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
